bus_traffic_gen: RTL and testbench

Parametrised bus-master traffic generator that stands in for a CPU on the SoC memory bus during bring-up. It issues periodic write, read or write-then-readback transactions over a configurable set of channel addresses using a valid/ready handshake. In readback mode it checks read data against the value just written and counts mismatches. It sits in the master slot of the bus and drives peripherals such as GPIO without a real core.

---
 rtl/bus_traffic_gen.sv | 183 ++++++++++++++++++
 tb/tb_bus_traffic_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_traffic_gen.sv
// Bus-master traffic generator: periodic write / read / write-then-readback over NUM_CH channel addresses.
// Requests are registered (valid one cycle after a tick) and held stable under backpressure; ticks seen while busy are dropped.
module bus_traffic_gen #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_2000,
  parameter int                STRIDE    = 4,
  parameter int                PERIOD    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic                  valid,
  input  logic                  ready,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DATA_W-1:0]     last_rdata,
  output logic [15:0]           txn_count,
  output logic [15:0]           err_count
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_RD  = 2'd2;
  localparam logic [1:0] MODE_WRB = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   seq_q, seq_d;
  logic [1:0]          act_mode_q, act_mode_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   last_rdata_q, last_rdata_d;
  logic [15:0]         txn_count_q, txn_count_d;
  logic [15:0]         err_count_q, err_count_d;

  logic                tick;
  logic                hs;
  logic                set_done;
  logic [ADDR_W-1:0]   ch_addr;

  assign ch_addr = BASE_ADDR + ADDR_W'(ch_q) * ADDR_W'(STRIDE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    seq_d        = seq_q;
    act_mode_d   = act_mode_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    last_rdata_d = last_rdata_q;
    txn_count_d  = txn_count_q;
    err_count_d  = err_count_q;
    set_done     = 1'b0;

    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    tick = enable && (cnt_q == '0);
    hs   = valid_q && ready;

    case (state_q)
      S_IDLE: begin
        if (tick && (mode != MODE_OFF)) begin
          act_mode_d = mode;
          addr_d     = ch_addr;
          wdata_d    = seq_q;
          valid_d    = 1'b1;
          if (mode == MODE_RD) begin
            state_d = S_RD;
            wstrb_d = '0;
          end else begin
            state_d = S_WR;
            wstrb_d = '1;
          end
        end
      end
      S_WR: begin
        if (hs) begin
          txn_count_d = txn_count_q + 16'd1;
          if (act_mode_q == MODE_WRB) begin
            // Readback reuses addr_q and keeps valid high: no bubble between the two phases.
            state_d = S_RD;
            wstrb_d = '0;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      S_RD: begin
        if (hs) begin
          txn_count_d  = txn_count_q + 16'd1;
          last_rdata_d = rdata;
          // wdata_q still holds the value written in this set.
          if ((act_mode_q == MODE_WRB) && (rdata != wdata_q) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          set_done = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (set_done) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      wstrb_d = '0;
      ch_d    = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
      if (act_mode_q != MODE_RD) begin
        seq_d = seq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      seq_q        <= '0;
      act_mode_q   <= MODE_OFF;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      last_rdata_q <= '0;
      txn_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      seq_q        <= seq_d;
      act_mode_q   <= act_mode_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      last_rdata_q <= last_rdata_d;
      txn_count_q  <= txn_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign valid      = valid_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign last_rdata = last_rdata_q;
  assign txn_count  = txn_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_bus_traffic_gen.sv
// Bench for bus_traffic_gen: directed scenarios plus random traffic, checked against a transaction-queue model.
module tb_bus_traffic_gen;

  localparam int          NUM_CH = 4;
  localparam int          PERIOD = 8;
  localparam logic [31:0] BASE   = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic [31:0] last_rdata;
  logic [15:0] txn_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  bus_traffic_gen dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .valid      (valid),
    .ready      (ready),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .rdata      (rdata),
    .last_rdata (last_rdata),
    .txn_count  (txn_count),
    .err_count  (err_count)
  );

  // One pending bus request; a transaction set is the group of requests pushed at one tick.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ch;
    bit          is_rd;
    bit          chk;
    bit          wrote;
  } req_t;

  req_t        q[$];
  int unsigned m_ch;
  int unsigned m_run;
  logic [31:0] m_seq;
  logic [31:0] m_last;
  logic [15:0] m_txn;
  logic [15:0] m_err;
  logic [31:0] mem [NUM_CH];
  int          rd_kind;   // 0 echo, 1 echo^1, 2 DEADBEEF, 3 random
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ch   = 0;
    m_run  = 0;
    m_seq  = '0;
    m_last = '0;
    m_txn  = '0;
    m_err  = '0;
    for (int i = 0; i < NUM_CH; i++) mem[i] = '0;
  endtask

  task automatic push_set(input logic [1:0] md);
    req_t e;
    e.addr  = BASE + 32'(m_ch) * 32'd4;
    e.wdata = m_seq;
    e.ch    = int'(m_ch);
    e.wrote = (md != 2'd2);
    e.is_rd = (md == 2'd2);
    e.chk   = 1'b0;
    q.push_back(e);
    if (md == 2'd3) begin
      e.is_rd = 1'b1;
      e.chk   = 1'b1;
      q.push_back(e);
    end
  endtask

  // Advance one clock: predict the edge from current inputs, then check outputs at the negedge.
  task automatic cycle();
    req_t e;
    bit   idle_before;
    bit   was_reset;
    was_reset = reset;
    if (q.size() != 0 && q[0].is_rd) begin
      case (rd_kind)
        0:       rdata = mem[q[0].ch];
        1:       rdata = mem[q[0].ch] ^ 32'd1;
        2:       rdata = 32'hDEADBEEF;
        default: rdata = $urandom;
      endcase
    end else begin
      rdata = $urandom;
    end

    if (reset) begin
      model_reset();
    end else begin
      idle_before = (q.size() == 0);
      if (!idle_before && ready) begin
        e = q.pop_front();
        m_txn++;
        if (e.is_rd) begin
          m_last = rdata;
          if (e.chk && rdata != e.wdata && m_err != 16'hFFFF) m_err++;
        end else begin
          mem[e.ch] = e.wdata;
        end
        if (q.size() == 0) begin
          m_ch = (m_ch + 1) % NUM_CH;
          if (e.wrote) m_seq++;
        end
      end
      if (enable && (m_run % PERIOD == 0) && idle_before && mode != 2'd0) push_set(mode);
      m_run = enable ? m_run + 1 : 0;
    end

    @(posedge clk);
    @(negedge clk);

    chk("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("addr", addr, q[0].addr);
      chk("wstrb", wstrb, q[0].is_rd ? 4'h0 : 4'hF);
      if (!q[0].is_rd) chk("wdata", wdata, q[0].wdata);
    end
    chk("txn_count", txn_count, m_txn);
    chk("err_count", err_count, m_err);
    chk("last_rdata", last_rdata, m_last);
    if (was_reset) begin
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", wstrb, 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    ready  = 1'b0;
    run(2);
    reset = 1'b0;
    run(1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, valid, 1);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    mode    = 2'd0;
    ready   = 1'b0;
    rdata   = '0;
    rd_kind = 0;
    model_reset();
    @(negedge clk);

    // Reset values
    do_reset();
    chk("reset_valid", valid, 0);
    chk("reset_txn", txn_count, 0);
    chk("reset_err", err_count, 0);
    chk("reset_last", last_rdata, 0);

    // Mode 1, ready tied high: five writes in 34 cycles
    enable = 1'b1; mode = 2'd1; ready = 1'b1;
    cycle();
    chk("m1_first_valid", valid, 1);
    chk("m1_first_addr", addr, 32'h2000);
    run(33);
    chk("m1_txn", txn_count, 5);

    // Mode 3 echo: ten sets, no mismatches
    do_reset();
    enable = 1'b1; mode = 2'd3; ready = 1'b1; rd_kind = 0;
    run(80);
    chk("m3_txn", txn_count, 20);
    chk("m3_err", err_count, 0);

    // Mode 3 with corrupted readback: one error per set
    do_reset();
    enable = 1'b1; mode = 2'd3; ready = 1'b1; rd_kind = 1;
    run(40);
    chk("m3_bad_err", err_count, 5);

    // Saturation from a preloaded count
    enable = 1'b0;
    run(4);
    m_err = 16'hFFFD;
    force dut.err_count_q = 16'hFFFD;
    cycle();
    release dut.err_count_q;
    enable = 1'b1;
    run(48);
    chk("err_sat", err_count, 16'hFFFF);

    // Backpressure: 20-cycle stall during a write
    do_reset();
    enable = 1'b1; mode = 2'd1; ready = 1'b0; rd_kind = 0;
    wait_valid("bp_wait", 4);
    run(20);
    ready = 1'b1;
    cycle();
    chk("bp_txn", txn_count, 1);
    chk("bp_valid_drop", valid, 0);
    run(30);

    // Mode 2 constant read data
    do_reset();
    enable = 1'b1; mode = 2'd2; ready = 1'b1; rd_kind = 2;
    run(20);
    chk("m2_last", last_rdata, 32'hDEADBEEF);
    chk("m2_err", err_count, 0);
    mode = 2'd1;
    wait_valid("m2_wait", 16);
    chk("m2_seq_held", wdata, 0);
    run(4);

    // Mode switched 1 -> 3 during a write stays write-only
    do_reset();
    enable = 1'b1; mode = 2'd1; ready = 1'b0;
    wait_valid("sw_wait", 4);
    mode = 2'd3; ready = 1'b1;
    cycle();
    chk("sw_wr_only", valid, 0);
    run(20);

    // enable dropped during readback: RD completes, then silence
    do_reset();
    enable = 1'b1; mode = 2'd3; ready = 1'b1; rd_kind = 0;
    wait_valid("en_wait", 4);
    cycle();
    chk("en_rd_phase", wstrb, 0);
    enable = 1'b0;
    cycle();
    run(20);
    chk("en_txn", txn_count, 2);
    chk("en_idle", valid, 0);

    // Reset while a request is pending
    enable = 1'b1; mode = 2'd1; ready = 1'b0;
    wait_valid("rst_wait", 16);
    reset = 1'b1;
    cycle();
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_txn", txn_count, 0);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) rd_kind = ($urandom_range(0, 2) == 0) ? 3 : int'($urandom_range(0, 1));
      ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
